// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for PE operand feeders
package pe_pkg;

    localparam int PE_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/mult.sv
// rtl/mult.sv - single multiply PE; registers the truncated product of a and b when enabled
module mult #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc_out
);

    // Product register; only the low DATA_W bits are kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out <= '0;
        end else if (en) begin
            acc_out <= a * b;
        end
    end

endmodule

// File: rtl/pe_sync_fifo.sv
// rtl/pe_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and registered full/empty
module pe_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;

    // Next pointers and the flags they imply, so full/empty can be registered
    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, push_ok};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop_ok};
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage array; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pe_operand_feeder.sv
// rtl/pe_operand_feeder.sv - buffers operand pairs, issues a job to the mult PE and captures its products
module pe_operand_feeder
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              pe_en,
    output logic [DATA_W-1:0] pe_a,
    output logic [DATA_W-1:0] pe_b,
    input  logic [DATA_W-1:0] pe_result,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done
);

    feeder_state_t       state_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    issued_q;
    logic [1:0]          outst_q, outst_d;
    logic                pe_en_q, en_d1_q, en_d2_q;
    logic [DATA_W-1:0]   pe_a_q, pe_b_q, res_data_q;
    logic                busy_q, done_q;

    logic                fifo_full, fifo_empty;
    logic [2*DATA_W-1:0] fifo_rdata;
    logic                push, pop, capture;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full;
    assign pop      = (state_q == RUN) & ~fifo_empty & (issued_q < len_q);
    // en_d1 marks the cycle in which pe_result carries the product of an issued pair
    assign capture  = en_d1_q;

    pe_sync_fifo #(
        .DATA_W (2*DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wdata  ({in_a, in_b}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Outstanding products: +1 on issue, -1 on capture, both allowed together
    always_comb begin
        outst_d = outst_q;
        case ({pop, capture})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase
    end

    // Job FSM, issue path and result capture with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            outst_q    <= '0;
            pe_en_q    <= 1'b0;
            pe_a_q     <= '0;
            pe_b_q     <= '0;
            en_d1_q    <= 1'b0;
            en_d2_q    <= 1'b0;
            res_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            pe_en_q <= pop;
            en_d1_q <= pe_en_q;
            en_d2_q <= en_d1_q;
            outst_q <= outst_d;
            if (pop) begin
                pe_a_q   <= fifo_rdata[2*DATA_W-1:DATA_W];
                pe_b_q   <= fifo_rdata[DATA_W-1:0];
                issued_q <= issued_q + CNT_W'(1);
            end
            if (capture) begin
                res_data_q <= pe_result;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= RUN;
                            len_q    <= len;
                            issued_q <= '0;
                            outst_q  <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && (issued_q + CNT_W'(1) == len_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // done lines up with the last res_valid; busy drops one cycle later
                    if (outst_q == 2'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (outst_d == 2'd0) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pe_en     = pe_en_q;
    assign pe_a      = pe_a_q;
    assign pe_b      = pe_b_q;
    assign res_valid = en_d2_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb/tb_pe_operand_feeder.sv - directed self-checking bench for the feeder with a mult PE
module tb_pe_operand_feeder;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a, in_b;
    logic              pe_en;
    logic [DATA_W-1:0] pe_a, pe_b, pe_result;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int en_count = 0;
    int done_count = 0;
    int done_res_count = 0;
    int res_q[$];
    int res_cyc[$];

    always #5 clk = ~clk;

    pe_operand_feeder #(.DATA_W(DATA_W), .DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .pe_en     (pe_en),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_result (pe_result),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    mult #(.DATA_W(DATA_W)) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pe_en),
        .a       (pe_a),
        .b       (pe_b),
        .acc_out (pe_result)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_en) en_count++;
            if (res_valid) begin
                res_q.push_back(int'(res_data));
                res_cyc.push_back(cyc);
            end
            if (done) begin
                done_count++;
                if (res_valid) done_res_count++;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int res_at(input int i);
        return (i < res_q.size()) ? res_q[i] : -1;
    endfunction

    function automatic int cyc_gap(input int i);
        return (i + 1 < res_cyc.size()) ? res_cyc[i+1] - res_cyc[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        en_count       = 0;
        done_count     = 0;
        done_res_count = 0;
        res_q.delete();
        res_cyc.delete();
    endtask

    task automatic push_pair(input int a, input int b);
        in_valid = 1'b1;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic start_job(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check(tag, int'(done), 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_pe_en", int'(pe_en), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // single op
        clear_mon();
        push_pair(3, 5);
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        check("single_busy_rise", int'(busy), 1);
        check("single_no_en_yet", int'(pe_en), 0);
        step();
        check("single_pe_en", int'(pe_en), 1);
        check("single_pe_a", int'(pe_a), 3);
        check("single_pe_b", int'(pe_b), 5);
        step();
        check("single_en_one_cycle", int'(pe_en), 0);
        check("single_res_early", int'(res_valid), 0);
        step();
        check("single_res_valid", int'(res_valid), 1);
        check("single_res_data", int'(res_data), 15);
        check("single_done", int'(done), 1);
        check("single_busy_hold", int'(busy), 1);
        step();
        check("single_busy_fall", int'(busy), 0);
        check("single_done_pulse", int'(done), 0);
        check("single_en_count", en_count, 1);

        // truncation and streaming
        clear_mon();
        push_pair(16, 16);
        push_pair(255, 2);
        push_pair(200, 200);
        start_job(3);
        wait_done("stream_done_seen", 20);
        check("stream_count", res_q.size(), 3);
        check("stream_r0", res_at(0), 0);
        check("stream_r1", res_at(1), 254);
        check("stream_r2", res_at(2), 64);
        check("stream_gap0", cyc_gap(0), 1);
        check("stream_gap1", cyc_gap(1), 1);
        check("stream_done_with_res", done_res_count, 1);

        // backpressure
        clear_mon();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a = DATA_W'(2*k + 1);
            in_b = DATA_W'(2*k + 2);
            step();
            check($sformatf("bp_ready_%0d", k), int'(in_ready), (k < 3) ? 1 : 0);
        end
        in_valid = 1'b0;
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        check("bp_ready_pop_cycle", int'(in_ready), 0);
        step();
        check("bp_ready_after_pop", int'(in_ready), 1);
        wait_done("bp_done_seen", 20);
        check("bp_count", res_q.size(), 4);
        check("bp_r0", res_at(0), 2);
        check("bp_r1", res_at(1), 12);
        check("bp_r2", res_at(2), 30);
        check("bp_r3", res_at(3), 56);

        // fifo now empty (5th pair dropped); start while busy is ignored
        clear_mon();
        start_job(1);
        repeat (6) step();
        check("stall_no_en", en_count, 0);
        check("stall_busy", int'(busy), 1);
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        push_pair(11, 11);
        wait_done("ign_done_seen", 20);
        check("ign_count", res_q.size(), 1);
        check("ign_r0", res_at(0), 121);
        check("ign_en_count", en_count, 1);
        repeat (3) step();
        check("ign_busy_idle", int'(busy), 0);
        check("ign_done_once", done_count, 1);

        // starvation
        clear_mon();
        start_job(2);
        repeat (4) step();
        check("starve_no_en", en_count, 0);
        push_pair(6, 7);
        repeat (4) step();
        push_pair(20, 13);
        wait_done("starve_done_seen", 20);
        repeat (3) step();
        check("starve_count", res_q.size(), 2);
        check("starve_r0", res_at(0), 42);
        check("starve_r1", res_at(1), 4);
        check("starve_en_count", en_count, 2);
        check("starve_done_once", done_count, 1);

        // len = 0
        clear_mon();
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        check("len0_done", int'(done), 1);
        check("len0_busy", int'(busy), 0);
        step();
        check("len0_done_pulse", int'(done), 0);
        check("len0_busy_after", int'(busy), 0);
        check("len0_no_en", en_count, 0);

        // leftover entries carried into the next job
        clear_mon();
        push_pair(2, 3);
        push_pair(4, 5);
        push_pair(10, 10);
        start_job(2);
        wait_done("left_done1_seen", 20);
        check("left_count1", res_q.size(), 2);
        check("left_r0", res_at(0), 6);
        check("left_r1", res_at(1), 20);
        clear_mon();
        start_job(1);
        wait_done("left_done2_seen", 20);
        check("left_count2", res_q.size(), 1);
        check("left_r2", res_at(0), 100);

        // reset mid-job
        clear_mon();
        push_pair(7, 9);
        push_pair(8, 8);
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        step();
        check("mid_pe_en_before", int'(pe_en), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pe_en", int'(pe_en), 0);
        check("mid_rst_pe_a", int'(pe_a), 0);
        check("mid_rst_pe_b", int'(pe_b), 0);
        check("mid_rst_res_valid", int'(res_valid), 0);
        check("mid_rst_res_data", int'(res_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("mid_no_res_after", res_q.size(), 0);
        start_job(1);
        repeat (4) step();
        check("mid_fifo_empty", en_count, 0);
        push_pair(12, 12);
        wait_done("mid_done_seen", 20);
        check("mid_count", res_q.size(), 1);
        check("mid_r0", res_at(0), 144);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
